// File: rtl/axi_s3_pkg.sv
// Shared constants for the 3-slave AXI interconnect slice.
// Slave indices, default-slave index and read-ordering depth.
package axi_s3_pkg;

  localparam int NUM     = 3;
  localparam int DEF_SLV = NUM;
  localparam int W_SEL   = 2;

  localparam int SLV0 = 0;
  localparam int SLV1 = 1;
  localparam int SLV2 = 2;

  localparam int R_DEPTH = 8;

endpackage

// File: rtl/axi_r_order_fifo.sv
// Pointer FIFO recording target slaves of outstanding reads.
// Also exposes the post-update head so the grant can be registered.
module axi_r_order_fifo #(
  parameter  int W     = 2,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  head_o,
  output logic [W-1:0]  nxt_head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          nxt_empty_o,
  output logic [PW-1:0] count_o
);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  assign wr_d = wr_q + PW'(push_ok);
  assign rd_d = rd_q + PW'(pop_ok);

  assign nxt_empty_o = (wr_d == rd_d);

  // New head may be the entry being written this very cycle.
  always_comb begin
    nxt_head_o = mem_q[rd_d[AW-1:0]];
    if (push_ok && (rd_d[AW-1:0] == wr_q[AW-1:0]))
      nxt_head_o = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok)
      mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/axi_r_order_ctrl.sv
// Per-master read-ordering scheduler driving r_order_grant.
// Optional sticky ORDER_ERR checker under `AXI_R_ORDER_CHK_EN.
module axi_r_order_ctrl #(
  parameter  int NUM   = axi_s3_pkg::NUM,
  parameter  int W_SEL = axi_s3_pkg::W_SEL,
  parameter  int DEPTH = axi_s3_pkg::R_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             AXI_CLK,
  input  logic             AXI_RST,
  input  logic             M_ARVALID,
  input  logic             M_ARREADY,
  input  logic [W_SEL-1:0] M_ARSEL,
  input  logic             M_RVALID,
  input  logic             M_RREADY,
  input  logic             M_RLAST,
  output logic [NUM-1:0]   r_order_grant,
  output logic             AR_STALL,
`ifdef AXI_R_ORDER_CHK_EN
  output logic             ORDER_ERR,
`endif
  output logic [CW-1:0]    OT_CNT
);

  import axi_s3_pkg::*;

  logic             push;
  logic             pop;
  logic [W_SEL-1:0] head;
  logic [W_SEL-1:0] nxt_head;
  logic             full;
  logic             empty;
  logic             nxt_empty;
  logic [NUM-1:0]   grant_q, grant_d;

  assign push = M_ARVALID & M_ARREADY;
  assign pop  = M_RVALID & M_RREADY & M_RLAST;

  axi_r_order_fifo #(
    .W     (W_SEL),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (AXI_CLK),
    .rst_i       (AXI_RST),
    .push_i      (push),
    .pop_i       (pop),
    .data_i      (M_ARSEL),
    .head_o      (head),
    .nxt_head_o  (nxt_head),
    .full_o      (full),
    .empty_o     (empty),
    .nxt_empty_o (nxt_empty),
    .count_o     (OT_CNT)
  );

  // Default-slave head decodes to no grant.
  always_comb begin
    grant_d = '0;
    if (!nxt_empty) begin
      for (int i = 0; i < NUM; i++)
        grant_d[i] = (nxt_head == W_SEL'(i));
    end
  end

  always_ff @(posedge AXI_CLK) begin
    if (AXI_RST) grant_q <= '0;
    else         grant_q <= grant_d;
  end

  assign r_order_grant = grant_q;
  assign AR_STALL      = full;

`ifdef AXI_R_ORDER_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (push && full)                                  err_d = 1'b1;
    if (pop && empty)                                  err_d = 1'b1;
    if (pop && !empty && head == W_SEL'(DEF_SLV) &&
        grant_q != '0)                                 err_d = 1'b1;
  end

  always_ff @(posedge AXI_CLK) begin
    if (AXI_RST) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign ORDER_ERR = err_q;
`else
  logic unused_head;
  assign unused_head = ^{head, empty};
`endif

endmodule

// File: tb/tb_axi_r_order_ctrl.sv
// Testbench for axi_r_order_ctrl: directed scenarios plus random
// traffic against a queue-based ordering model.
module tb_axi_r_order_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       arvalid, arready;
  logic [1:0] arsel;
  logic       rvalid, rready, rlast;
  logic [2:0] grant;
  logic       stall;
  logic [3:0] ot;
`ifdef AXI_R_ORDER_CHK_EN
  logic       oerr;
`endif

  int total = 0;
  int passed = 0;

  logic [1:0] q [$];
  bit         exp_err;

  always #5 clk = ~clk;

  axi_r_order_ctrl dut (
    .AXI_CLK       (clk),
    .AXI_RST       (rst),
    .M_ARVALID     (arvalid),
    .M_ARREADY     (arready),
    .M_ARSEL       (arsel),
    .M_RVALID      (rvalid),
    .M_RREADY      (rready),
    .M_RLAST       (rlast),
    .r_order_grant (grant),
`ifdef AXI_R_ORDER_CHK_EN
    .ORDER_ERR     (oerr),
`endif
    .AR_STALL      (stall),
    .OT_CNT        (ot)
  );

  function automatic logic [2:0] exp_grant();
    logic [2:0] g;
    g = 3'b000;
    if (q.size() > 0 && q[0] < 2'd3) g[q[0]] = 1'b1;
    return g;
  endfunction

  // One clock: the model applies the ordering rules to the inputs
  // present at the edge, then outputs are sampled 1 time unit later.
  task automatic cyc();
    bit do_push, do_pop;
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_err = 0;
    end else begin
      do_push = arvalid && arready;
      do_pop  = rvalid && rready && rlast;
      if (do_push && q.size() == 8) exp_err = 1;
      if (do_pop && q.size() == 0)  exp_err = 1;
      if (do_pop && q.size() > 0) void'(q.pop_front());
      if (do_push && q.size() < 8 + (do_pop ? 1 : 0) &&
          !(q.size() == 8))
        q.push_back(arsel);
    end
    #1;
  endtask

  task automatic drive_ar(input bit v, input logic [1:0] s);
    arvalid = v;
    arsel   = s;
    arready = v && !stall;
  endtask

  task automatic drive_r(input bit v, input bit l);
    rvalid = v;
    rready = v;
    rlast  = l;
  endtask

  task automatic idle();
    drive_ar(0, 2'd0);
    drive_r(0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({grant, stall, ot} !== 8'd0)
      $display("FAIL reset_outputs grant=%b stall=%b ot=%0d need 0",
               grant, stall, ot);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    drive_ar(1, 2'd1);
    cyc();
    idle();
    total++;
    if (grant !== 3'b010 || ot !== 4'd1)
      $display("FAIL single_ar grant=%b ot=%0d need 010/1", grant, ot);
    else passed++;
    for (int b = 0; b < 4; b++) begin
      drive_r(1, b == 3);
      cyc();
      if (b < 3) begin
        total++;
        if (grant !== 3'b010 || ot !== 4'd1)
          $display("FAIL beat_hold%0d grant=%b ot=%0d need 010/1",
                   b, grant, ot);
        else passed++;
      end
    end
    idle();
    total++;
    if (grant !== 3'b000 || ot !== 4'd0)
      $display("FAIL single_done grant=%b ot=%0d need 000/0", grant, ot);
    else passed++;
  endtask

  task automatic test_order();
    logic [1:0] sels [3];
    logic [2:0] exp [3];
    sels = '{2'd2, 2'd0, 2'd1};
    exp  = '{3'b100, 3'b001, 3'b010};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_ar(1, sels[i]);
      cyc();
    end
    idle();
    drive_r(1, 0);
    cyc();
    total++;
    if (grant !== 3'b100)
      $display("FAIL early_s0_blocked grant=%b need 100", grant);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (grant !== exp[i])
        $display("FAIL order%0d grant=%b need %b", i, grant, exp[i]);
      else passed++;
      drive_r(1, 1);
      cyc();
    end
    idle();
    total++;
    if (grant !== 3'b000 || ot !== 4'd0)
      $display("FAIL order_drain grant=%b ot=%0d need 000/0", grant, ot);
    else passed++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_ar(1, 2'(i % 3));
      cyc();
    end
    total++;
    if (ot !== 4'd8 || stall !== 1'b1)
      $display("FAIL full ot=%0d stall=%b need 8/1", ot, stall);
    else passed++;
    drive_ar(1, 2'd2);
    cyc();
    total++;
    if (ot !== 4'd8 || arready !== 1'b0)
      $display("FAIL full_hold ot=%0d arready=%b need 8/0", ot, arready);
    else passed++;
    drive_r(1, 1);
    cyc();
    idle();
    total++;
    if (ot !== 4'd7 || stall !== 1'b0)
      $display("FAIL full_pop ot=%0d stall=%b need 7/0", ot, stall);
    else passed++;
  endtask

  task automatic test_simul();
    do_reset();
    drive_ar(1, 2'd0); cyc();
    drive_ar(1, 2'd1); cyc();
    drive_ar(1, 2'd2); cyc();
    drive_ar(1, 2'd0);
    drive_r(1, 1);
    cyc();
    idle();
    total++;
    if (ot !== 4'd3 || grant !== 3'b010)
      $display("FAIL simul ot=%0d grant=%b need 3/010", ot, grant);
    else passed++;
  endtask

  task automatic test_default();
    do_reset();
    drive_ar(1, 2'd3); cyc();
    drive_ar(1, 2'd0); cyc();
    idle();
    total++;
    if (grant !== 3'b000 || ot !== 4'd2)
      $display("FAIL default_head grant=%b ot=%0d need 000/2", grant, ot);
    else passed++;
    drive_r(1, 1);
    cyc();
    idle();
    total++;
    if (grant !== 3'b001 || ot !== 4'd1)
      $display("FAIL default_pop grant=%b ot=%0d need 001/1", grant, ot);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_ar(1, 2'd1);
      cyc();
    end
    drive_ar(0, 2'd0);
    drive_r(1, 0);
    cyc();
    total++;
    if (ot !== 4'd5)
      $display("FAIL mid_pre ot=%0d need 5", ot);
    else passed++;
    rst = 1;
    cyc();
    rst = 0;
    idle();
    total++;
    if ({grant, stall, ot} !== 8'd0)
      $display("FAIL mid_reset grant=%b stall=%b ot=%0d need 0",
               grant, stall, ot);
    else passed++;
`ifdef AXI_R_ORDER_CHK_EN
    total++;
    if (oerr !== 1'b0)
      $display("FAIL err_reset err=%b need 0", oerr);
    else passed++;
    drive_r(1, 1);
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (oerr !== 1'b1)
        $display("FAIL err_sticky%0d err=%b need 1", i, oerr);
      else passed++;
      cyc();
    end
    rst = 1;
    cyc();
    rst = 0;
    total++;
    if (oerr !== 1'b0)
      $display("FAIL err_clear err=%b need 0", oerr);
    else passed++;
`endif
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive_ar($urandom_range(0, 99) < 45,
               2'($urandom_range(0, 3)));
      drive_r($urandom_range(0, 99) < 50,
              $urandom_range(0, 2) == 0);
      cyc();
      total++;
      if (grant !== exp_grant() || ot !== 4'(q.size()) ||
          stall !== (q.size() == 8)) begin
        errs++;
        if (errs < 10)
          $display("FAIL rand%0d grant=%b ot=%0d stall=%b need %b/%0d/%b",
                   c, grant, ot, stall, exp_grant(), q.size(),
                   q.size() == 8);
      end else passed++;
`ifdef AXI_R_ORDER_CHK_EN
      total++;
      if (oerr !== exp_err) begin
        errs++;
        if (errs < 10)
          $display("FAIL rand_err%0d err=%b need %b", c, oerr, exp_err);
      end else passed++;
`endif
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    exp_err = 0;
    test_reset();
    test_single();
    test_order();
    test_full();
    test_simul();
    test_default();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_r_order_ctrl.md
Name: axi_r_order_ctrl

Overview:
Per-master read-ordering scheduler that generates r_order_grant for the master's slave-to-master return mux.
- Records, in issue order, the target slave of every accepted AR on that master.
- Enables only the slave at the head of that record onto the R return path, so read bursts to different slaves complete in issue order.
- Back-pressures AR issue when the outstanding-read record is full.

Parameters:
NUM, 3, number of real slaves (S0..S2); the default slave has index NUM.
W_SEL, 2, width of the slave index; must satisfy 2**W_SEL >= NUM+1.
DEPTH, 8, maximum outstanding reads per master; power of two, >= 2.

Ports:
AXI_CLK  input  1  clock; all logic on the rising edge.
AXI_RST  input  1  synchronous active-high reset.
M_ARVALID  input  1  master AR valid, after the slave decode.
M_ARREADY  input  1  master AR ready, as returned to the master (already gated by AR_STALL).
M_ARSEL  input  W_SEL  decoded slave index of the current AR: 0..NUM-1 real slave, NUM default slave.
M_RVALID  input  1  master-side R valid (mux output).
M_RREADY  input  1  master R ready.
M_RLAST  input  1  master-side R last.
r_order_grant  output  NUM  one-hot enable of the real slave allowed onto R; all zero when empty or head is the default slave.
AR_STALL  output  1  high when the record is full; the AR path must drop ARREADY while high.
OT_CNT  output  $clog2(DEPTH)+1  number of outstanding reads.

Behaviour:
- Push: M_ARVALID & M_ARREADY writes M_ARSEL at the write pointer.
- Pop: M_RVALID & M_RREADY & M_RLAST removes the head entry. Non-last beats never pop.
- Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - Empty: pointers equal.
  - Full: MSBs differ and the lower bits are equal.
- OT_CNT = wr_ptr - rd_ptr (modulo). It ranges 0..DEPTH.
- AR_STALL = full. It is registered-derived with no combinational path from any input.
- r_order_grant is a register:
  - Next value = onehot(new head) when the record is non-empty after the update and the new head < NUM; otherwise 0.
  - Latency: an AR accepted into an empty record gives a grant on the next cycle. A pop gives the next head's grant on the next cycle.
  - R beats are therefore never granted in the cycle of the AR handshake.
- Simultaneous push and pop:
  - When the record is non-empty, both occur and OT_CNT is unchanged.
  - When the record is empty, the pop is ignored and the push occurs.
- Push while full: ignored, and no pointer moves. The upstream gating makes this illegal.
- Pop while empty: ignored.
- Default-slave head: grant is 000. Default-slave R is always admitted downstream. Its RLAST pops the head.
- Reset, including in the middle of bursts: pointers 0, OT_CNT 0, r_order_grant 0, AR_STALL 0. Record contents are don't-care.
- There is no ID-based reordering: ordering is strict and global per master.

Optional Feature:
AXI_R_ORDER_CHK_EN
- Defined: adds output ORDER_ERR (1 bit, sticky, cleared only by AXI_RST). It sets in the cycle after any of:
  - a push while full;
  - a pop while empty;
  - a pop whose head index is NUM while r_order_grant != 0.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package axi_s3_pkg holds:
  - NUM = 3;
  - DEF_SLV = NUM;
  - W_SEL = 2;
  - the slave index constants SLV0..SLV2;
  - the DEPTH default.
- One sub-module, axi_r_order_fifo: a synchronous pointer FIFO of width W_SEL and depth DEPTH with push, pop, head, full, empty and count.
- axi_r_order_ctrl adds the push/pop qualification, the registered one-hot grant decode and the optional checker.

Test Plan:
1. Reset, then AR to SEL=1: next cycle r_order_grant=010, OT_CNT=1. Four R beats with RLAST on the 4th: the cycle after the last beat, grant=000 and OT_CNT=0.
2. ARs to SEL 2, 0, 1 back-to-back: grant=100 until S2's RLAST, then 001, then 010. An S0 RVALID raised early is not granted while the head is 2.
3. Issue 8 ARs with no R: OT_CNT=8 and AR_STALL=1. A 9th ARVALID holds. One RLAST pop gives AR_STALL=0 and OT_CNT=7 the next cycle.
4. Record of 3 entries; in the same cycle, an AR handshake and an RLAST pop: OT_CNT stays 3, and grant moves to the second entry.
5. AR to SEL=3 (default) then SEL=0: grant=000. The default RLAST pops; then grant=001.
6. AXI_RST asserted mid-burst with OT_CNT=5: the next cycle shows all outputs zero. With AXI_R_ORDER_CHK_EN, a pop while empty sets ORDER_ERR=1, and it holds until reset.
